systolic_seq_ctrl: RTL and testbench



---
 rtl/systolic_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/systolic_seq_ctrl.sv
// Run sequencer for the systolic array: weight load, activation feed, pipeline drain, done handshake.
// Optional macro WEIGHT_REUSE_EN keeps a weights-valid flag so a run can skip the weight load.
module systolic_seq_ctrl #(
   parameter int ARRAY_N = 8,
   parameter int NUM_VEC = 8,
   parameter int CNT_W   = 5
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic             abort,
   input  logic             reuse_w,
   output logic             busy,
   output logic             done,
   output logic             w_load_en,
   output logic [CNT_W-1:0] w_row_idx,
   output logic             feed_en,
   output logic [CNT_W-1:0] feed_idx,
   output logic             acc_en,
   output logic [CNT_W-1:0] phase_cnt
);

   typedef enum logic [2:0] {IDLE, LOAD_W, FEED, DRAIN, DONE} state_t;

   localparam bit               HAS_DRAIN  = (ARRAY_N > 1);
   localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(ARRAY_N - 1);
   localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(NUM_VEC - 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((ARRAY_N > 1) ? 2*ARRAY_N - 3 : 0);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             reuse_ok;

`ifdef WEIGHT_REUSE_EN
   logic wvalid;

   // Valid only once a full load completes; a load cut short by abort leaves the array suspect.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wvalid <= 1'b0;
      end else if (state == LOAD_W) begin
         if (abort)
            wvalid <= 1'b0;
         else if (cnt == LOAD_LAST)
            wvalid <= 1'b1;
      end
   end

   assign reuse_ok = reuse_w & wvalid;
`else
   logic unused_reuse;
   assign unused_reuse = reuse_w;
   assign reuse_ok     = 1'b0;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      done      = 1'b0;
      w_load_en = 1'b0;
      w_row_idx = '0;
      feed_en   = 1'b0;
      feed_idx  = '0;
      acc_en    = 1'b0;
      case (state)
         IDLE: begin
            if (start && !abort)
               state_nxt = reuse_ok ? FEED : LOAD_W;
         end
         LOAD_W: begin
            w_load_en = 1'b1;
            w_row_idx = cnt;
            if (abort)
               state_nxt = IDLE;
            else if (cnt == LOAD_LAST)
               state_nxt = FEED;
            else
               cnt_nxt = cnt + CNT_W'(1);
         end
         FEED: begin
            feed_en  = 1'b1;
            acc_en   = 1'b1;
            feed_idx = cnt;
            if (abort)
               state_nxt = IDLE;
            else if (cnt == FEED_LAST)
               state_nxt = HAS_DRAIN ? DRAIN : DONE;
            else
               cnt_nxt = cnt + CNT_W'(1);
         end
         DRAIN: begin
            acc_en = 1'b1;
            if (abort)
               state_nxt = IDLE;
            else if (cnt == DRAIN_LAST)
               state_nxt = DONE;
            else
               cnt_nxt = cnt + CNT_W'(1);
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy      = (state != IDLE);
   assign phase_cnt = cnt;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Randomized bench for systolic_seq_ctrl: three parameterizations against a run-timeline reference model.
module tb_systolic_seq_ctrl;

`ifdef WEIGHT_REUSE_EN
   localparam bit REUSE = 1'b1;
`else
   localparam bit REUSE = 1'b0;
`endif
   localparam int NA[3] = '{8, 4, 1};
   localparam int NV[3] = '{8, 1, 3};

   logic       clk = 1'b0;
   logic       rstn, start, abort, reuse_w;
   logic       busy_o[3], done_o[3], wl_o[3], fe_o[3], acc_o[3];
   logic [4:0] widx_o[3], fidx_o[3], pc_o[3];

   int n_cmp = 0;
   int n_err = 0;
   int pos[3];
   bit sk[3];
   bit wv[3];

   always #5 clk = ~clk;

   systolic_seq_ctrl #(.ARRAY_N(8), .NUM_VEC(8), .CNT_W(5)) u_dut0 (
      .clk(clk), .rstn(rstn), .start(start), .abort(abort), .reuse_w(reuse_w),
      .busy(busy_o[0]), .done(done_o[0]), .w_load_en(wl_o[0]), .w_row_idx(widx_o[0]),
      .feed_en(fe_o[0]), .feed_idx(fidx_o[0]), .acc_en(acc_o[0]), .phase_cnt(pc_o[0]));

   systolic_seq_ctrl #(.ARRAY_N(4), .NUM_VEC(1), .CNT_W(5)) u_dut1 (
      .clk(clk), .rstn(rstn), .start(start), .abort(abort), .reuse_w(reuse_w),
      .busy(busy_o[1]), .done(done_o[1]), .w_load_en(wl_o[1]), .w_row_idx(widx_o[1]),
      .feed_en(fe_o[1]), .feed_idx(fidx_o[1]), .acc_en(acc_o[1]), .phase_cnt(pc_o[1]));

   systolic_seq_ctrl #(.ARRAY_N(1), .NUM_VEC(3), .CNT_W(5)) u_dut2 (
      .clk(clk), .rstn(rstn), .start(start), .abort(abort), .reuse_w(reuse_w),
      .busy(busy_o[2]), .done(done_o[2]), .w_load_en(wl_o[2]), .w_row_idx(widx_o[2]),
      .feed_en(fe_o[2]), .feed_idx(fidx_o[2]), .acc_en(acc_o[2]), .phase_cnt(pc_o[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   function automatic int run_len(input int n, input int v, input bit skip);
      return (skip ? 0 : n) + v + ((n > 1) ? 2*n - 2 : 0) + 1;
   endfunction

   // Outputs as a function of the 1-based cycle position inside a run (0 = idle).
   function automatic void expect_at(input int n, input int v, input bit skip, input int p,
                                     output bit b, output bit d, output bit wl, output bit fe,
                                     output bit ac, output int wi, output int fi, output int pc);
      int ld, len;
      ld  = skip ? 0 : n;
      len = run_len(n, v, skip);
      b = (p != 0); d = (p == len);
      wl = 0; fe = 0; ac = 0; wi = 0; fi = 0; pc = 0;
      if (p >= 1 && p <= ld) begin
         wl = 1; wi = p - 1; pc = p - 1;
      end else if (p > ld && p <= ld + v) begin
         fe = 1; ac = 1; fi = p - ld - 1; pc = fi;
      end else if (p > ld + v && p < len) begin
         ac = 1; pc = p - ld - v - 1;
      end
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         pos[i] = 0; sk[i] = 0; wv[i] = 0;
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < 3; i++) begin
         if (!rstn) begin
            pos[i] = 0; sk[i] = 0; wv[i] = 0;
         end else if (pos[i] == 0) begin
            if (start && !abort) begin
               pos[i] = 1;
               sk[i]  = REUSE && reuse_w && wv[i];
            end
         end else if (abort) begin
            if (!sk[i] && pos[i] <= NA[i]) wv[i] = 0;
            pos[i] = 0;
         end else if (pos[i] == run_len(NA[i], NV[i], sk[i])) begin
            pos[i] = 0;
         end else begin
            if (!sk[i] && pos[i] == NA[i]) wv[i] = 1;
            pos[i]++;
         end
      end
   endtask

   task automatic check_all();
      bit b, d, wl, fe, ac;
      int wi, fi, pc;
      for (int i = 0; i < 3; i++) begin
         expect_at(NA[i], NV[i], sk[i], pos[i], b, d, wl, fe, ac, wi, fi, pc);
         check($sformatf("busy%0d", i), 32'(busy_o[i]), 32'(b));
         check($sformatf("done%0d", i), 32'(done_o[i]), 32'(d));
         check($sformatf("w_load_en%0d", i), 32'(wl_o[i]), 32'(wl));
         check($sformatf("w_row_idx%0d", i), 32'(widx_o[i]), wi);
         check($sformatf("feed_en%0d", i), 32'(fe_o[i]), 32'(fe));
         check($sformatf("feed_idx%0d", i), 32'(fidx_o[i]), fi);
         check($sformatf("acc_en%0d", i), 32'(acc_o[i]), 32'(ac));
         check($sformatf("phase_cnt%0d", i), 32'(pc_o[i]), pc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic run_measure(input bit r, input int exp_len);
      int n, nd, nw;
      start = 1; reuse_w = r;
      step();
      start = 0; reuse_w = 0;
      n = 0; nd = 0; nw = 0;
      for (int k = 0; k < 60 && busy_o[0]; k++) begin
         n++;
         if (done_o[0]) nd++;
         if (wl_o[0]) nw++;
         step();
      end
      check("run_len", n, exp_len);
      check("done_pulses", nd, 1);
      check("load_cycles", nw, (exp_len == 31) ? 8 : 0);
   endtask

   initial begin
      rstn = 0; start = 0; abort = 0; reuse_w = 0;
      model_reset();
      #1 check_all();
      step(); step();
      rstn = 1;
      step();

      run_measure(0, 31);

      start = 1;
      for (int k = 0; k < 70; k++) step();
      start = 0;
      for (int k = 0; k < 35; k++) step();

      start = 1; step(); start = 0;
      for (int k = 0; k < 40 && pos[0] != 12; k++) step();
      check("reach_feed3", pos[0], 12);
      abort = 1; step(); abort = 0;
      check("abort_busy", 32'(busy_o[0]), 0);
      for (int k = 0; k < 3; k++) step();
      run_measure(0, 31);

      start = 1; step(); start = 0;
      for (int k = 0; k < 40 && pos[0] != 20; k++) step();
      check("reach_drain", pos[0], 20);
      #2 rstn = 0;
      model_reset();
      #1 check_all();
      step(); step();
      rstn = 1;
      for (int k = 0; k < 5; k++) step();

      run_measure(1, 31);
      step();
      run_measure(1, REUSE ? 23 : 31);

      start = 1; abort = 1; step(); start = 0; abort = 0;
      step();

      for (int k = 0; k < 3000; k++) begin
         start   = ($urandom % 4) == 0;
         abort   = ($urandom % 40) == 0;
         reuse_w = $urandom % 2;
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
